fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS32 pipeline, sitting directly upstream of the byte-addressed 8 KB instruction memory. It owns the program counter, drives the 13-bit memory address, and captures the returned 32-bit word into the IF/ID pipeline register. It handles stall, branch/jump redirect, flush, and an optional branch delay slot. The decode stage consumes its outputs.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: reset PC, IM address width, fetch select and IF/ID types.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam int unsigned DEFAULT_IM_AW    = 13;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Source of the next PC on a non-reset edge.
    typedef enum logic [1:0] {
        PcHold,
        PcRedirect,
        PcPend,
        PcSeq
    } pc_sel_e;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        IfHold,
        IfFlush,
        IfLoad,
        IfSquash
    } if_id_ctrl_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, flush, load and squash control.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  if_id_ctrl_e ctrl,
    input  logic [31:0] fetch_inst,
    input  logic [31:0] fetch_pc,
    output if_id_t      if_id
);

    if_id_t regs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs.valid <= 1'b0;
            regs.inst  <= INST_NOP;
            regs.pc    <= 32'h0;
        end else begin
            unique case (ctrl)
                IfHold: begin
                end
                // inst/pc are meaningless once invalid, so they are simply left alone.
                IfFlush: begin
                    regs.valid <= 1'b0;
                end
                IfLoad: begin
                    regs.valid <= 1'b1;
                    regs.inst  <= fetch_inst;
                    regs.pc    <= fetch_pc;
                end
                IfSquash: begin
                    regs.valid <= 1'b0;
                    regs.inst  <= fetch_inst;
                    regs.pc    <= fetch_pc;
                end
                default: begin
                end
            endcase
        end
    end

    assign if_id = regs;

endmodule

// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: PC, pending redirect and IF/ID register.
// Build option DELAY_SLOT_EN keeps the word fetched on a redirect edge valid as the delay slot.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_AW    = DEFAULT_IM_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             flush_i,
    output logic [IM_AW-1:0] im_addr_o,
    input  logic [31:0]      im_inst_i,
    output logic             if_valid_o,
    output logic [31:0]      if_inst_o,
    output logic [31:0]      if_pc_o,
    output logic [31:0]      if_pc4_o
);

    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [31:0] target_pc;
    logic        redirect_taken;
    pc_sel_e     pc_sel;
    if_id_ctrl_e if_id_ctrl;
    if_id_t      if_id;

    assign target_pc      = align_pc(redirect_pc_i);
    assign redirect_taken = !stall_i && (redirect_i || pend_valid);

    always_comb begin
        pc_sel = PcSeq;
        if (stall_i) begin
            pc_sel = PcHold;
        end else if (redirect_i) begin
            pc_sel = PcRedirect;
        end else if (pend_valid) begin
            pc_sel = PcPend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
        end else begin
            unique case (pc_sel)
                // A redirect arriving while stalled is parked; a newer one overwrites it.
                PcHold: begin
                    if (redirect_i) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= target_pc;
                    end
                end
                PcRedirect: begin
                    pc         <= target_pc;
                    pend_valid <= 1'b0;
                end
                PcPend: begin
                    pc         <= pend_pc;
                    pend_valid <= 1'b0;
                end
                PcSeq: begin
                    pc <= pc + PC_STEP;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        if_id_ctrl = IfLoad;
        if (flush_i) begin
            if_id_ctrl = IfFlush;
        end else if (stall_i) begin
            if_id_ctrl = IfHold;
        end else if (redirect_taken) begin
`ifdef DELAY_SLOT_EN
            if_id_ctrl = IfLoad;
`else
            if_id_ctrl = IfSquash;
`endif
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl       (if_id_ctrl),
        .fetch_inst (im_inst_i),
        .fetch_pc   (pc),
        .if_id      (if_id)
    );

    assign im_addr_o  = pc[IM_AW-1:0];
    assign if_valid_o = if_id.valid;
    assign if_inst_o  = if_id.inst;
    assign if_pc_o    = if_id.pc;
    assign if_pc4_o   = if_id.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns {16'hA5A5, 3'b0, addr} for each byte address.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        flush_i;
    logic [12:0] im_addr_o;
    logic [31:0] im_inst_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;

    int n_pass;
    int n_checks;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] DS = 32'd1;
`else
    localparam logic [31:0] DS = 32'd0;
`endif

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .flush_i       (flush_i),
        .im_addr_o     (im_addr_o),
        .im_inst_i     (im_inst_i),
        .if_valid_o    (if_valid_o),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o),
        .if_pc4_o      (if_pc4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign im_inst_i = {16'hA5A5, 3'b000, im_addr_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] v, input logic [31:0] pc);
        check({tag, "_valid"}, {31'h0, if_valid_o}, v);
        check({tag, "_pc"}, if_pc_o, pc);
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        flush_i = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_addr", {19'h0, im_addr_o}, 32'h1000);
        check("rst_valid", {31'h0, if_valid_o}, 32'h0);
        check("rst_inst", if_inst_o, 32'h0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_pc4", if_pc4_o, 32'h4);

        // Sequential fetch
        rst_n = 1'b1;
        tick();
        check("seq1_addr", {19'h0, im_addr_o}, 32'h1004);
        check_ifid("seq1", 32'h1, 32'h3000);
        check("seq1_inst", if_inst_o, 32'hA5A5_1000);
        check("seq1_pc4", if_pc4_o, 32'h3004);
        tick();
        check("seq2_addr", {19'h0, im_addr_o}, 32'h1008);
        check_ifid("seq2", 32'h1, 32'h3004);

        // Unstalled redirect at pc 0x3008
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3100;
        tick();
        redirect_i = 1'b0;
        check("redir_addr", {19'h0, im_addr_o}, 32'h1100);
        check_ifid("redir_slot", DS, 32'h3008);
        check("redir_slot_inst", if_inst_o, 32'hA5A5_1008);
        tick();
        check("redir_tgt_addr", {19'h0, im_addr_o}, 32'h1104);
        check_ifid("redir_tgt", 32'h1, 32'h3100);
        check("redir_tgt_inst", if_inst_o, 32'hA5A5_1100);

        // Three-cycle stall with redirect to 0x3200 in the first
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3200;
        tick();
        redirect_i = 1'b0;
        check("stall1_addr", {19'h0, im_addr_o}, 32'h1104);
        check_ifid("stall1", 32'h1, 32'h3100);
        tick();
        tick();
        check("stall3_addr", {19'h0, im_addr_o}, 32'h1104);
        check_ifid("stall3", 32'h1, 32'h3100);
        check("stall3_inst", if_inst_o, 32'hA5A5_1100);
        stall_i = 1'b0;
        tick();
        check("pend_addr", {19'h0, im_addr_o}, 32'h1200);
        check_ifid("pend_slot", DS, 32'h3104);
        tick();
        check("pend_next_addr", {19'h0, im_addr_o}, 32'h1204);
        check_ifid("pend_tgt", 32'h1, 32'h3200);

        // Flush beats stall; PC held
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        stall_i = 1'b0;
        flush_i = 1'b0;
        check("flush_valid", {31'h0, if_valid_o}, 32'h0);
        check("flush_addr", {19'h0, im_addr_o}, 32'h1204);
        tick();
        check("flush_rel_addr", {19'h0, im_addr_o}, 32'h1208);
        check_ifid("flush_rel", 32'h1, 32'h3204);

        // flush + redirect + stall together
        stall_i = 1'b1;
        flush_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3300;
        tick();
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_i = 1'b0;
        check("fsr_valid", {31'h0, if_valid_o}, 32'h0);
        check("fsr_addr", {19'h0, im_addr_o}, 32'h1208);
        tick();
        check("fsr_pend_addr", {19'h0, im_addr_o}, 32'h1300);
        check_ifid("fsr_slot", DS, 32'h3208);

        // Fresh redirect on the release edge beats the pending one
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3400;
        tick();
        stall_i = 1'b0;
        redirect_pc_i = 32'h0000_3500;
        tick();
        redirect_i = 1'b0;
        check("fresh_addr", {19'h0, im_addr_o}, 32'h1500);
        tick();
        check("fresh_seq_addr", {19'h0, im_addr_o}, 32'h1504);

        // Misaligned target is word aligned
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3103;
        tick();
        redirect_i = 1'b0;
        check("align_addr", {19'h0, im_addr_o}, 32'h1100);
        tick();
        check_ifid("align_tgt", 32'h1, 32'h3100);

        // PC wrap and IM aliasing
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        check("wrap_addr0", {19'h0, im_addr_o}, 32'h1FFC);
        tick();
        check("wrap_addr1", {19'h0, im_addr_o}, 32'h0000);
        tick();
        check_ifid("wrap_ifid", 32'h1, 32'h0000_0000);
        tick();
        check("wrap_pc4", if_pc4_o, 32'h0000_0008);

        // Reset with a pending redirect drops it
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_3600;
        tick();
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        tick();
        check("rst2_addr", {19'h0, im_addr_o}, 32'h1000);
        check_ifid("rst2", 32'h0, 32'h0);
        check("rst2_pc4", if_pc4_o, 32'h4);
        rst_n = 1'b1;
        tick();
        check("rst2_seq_addr", {19'h0, im_addr_o}, 32'h1004);
        check_ifid("rst2_seq", 32'h1, 32'h3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
